// File: rtl/moldudp64_top_if.sv
// Bus bundle for the MoldUDP64 parser: upstream UDP payload stream in, lane-aligned message stream out.
interface moldudp64_top_if #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int ML_W       = 16
);
  logic                  upd_axis_tvalid_i;
  logic [AXI_KEEP_W-1:0] upd_axis_tkeep_i;
  logic [AXI_DATA_W-1:0] upd_axis_tdata_i;
  logic                  upd_axis_tlast_i;
  logic                  upd_axis_tuser_i;
  logic                  upd_axis_tready_o;
  logic                  mold_msg_v_o;
  logic                  mold_msg_start_o;
  logic [ML_W-1:0]       mold_msg_len_o;
  logic [AXI_KEEP_W-1:0] mold_msg_mask_o;
  logic [AXI_DATA_W-1:0] mold_msg_data_o;

  modport master (
    output upd_axis_tvalid_i, upd_axis_tkeep_i, upd_axis_tdata_i, upd_axis_tlast_i, upd_axis_tuser_i,
    input  upd_axis_tready_o,
    input  mold_msg_v_o, mold_msg_start_o, mold_msg_len_o, mold_msg_mask_o, mold_msg_data_o
  );

  modport slave (
    input  upd_axis_tvalid_i, upd_axis_tkeep_i, upd_axis_tdata_i, upd_axis_tlast_i, upd_axis_tuser_i,
    output upd_axis_tready_o,
    output mold_msg_v_o, mold_msg_start_o, mold_msg_len_o, mold_msg_mask_o, mold_msg_data_o
  );
endinterface

// File: rtl/moldudp64_top.sv
// MoldUDP64 receive parser: strips the 20-byte header and walks length-prefixed message blocks,
// emitting payload lanes per message with mask/start/len. Beats holding two messages are replayed.
module moldudp64_top #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int ML_W       = 16
) (
  input  logic              clk,
  input  logic              nreset,
  moldudp64_top_if.slave    bus
);

  typedef enum logic [1:0] {HDR, LEN, PAY, DRAIN} state_e;

  state_e                st_q, st_d;
  logic [4:0]            hcnt_q, hcnt_d;
  logic [ML_W-1:0]       cnt_q, cnt_d;
  logic [ML_W-1:0]       rem_q, rem_d;
  logic [ML_W-1:0]       mlen_q, mlen_d;
  logic [7:0]            lenlo_q, lenlo_d;
  logic                  lph_q, lph_d;
  logic                  first_q, first_d;
  logic                  hold_q, hold_d;
  logic [2:0]            pos_q, pos_d;
  logic [AXI_DATA_W-1:0] hdata_q, hdata_d;
  logic [AXI_KEEP_W-1:0] hkeep_q, hkeep_d;
  logic                  hlast_q, hlast_d;
  logic                  rdy_q, rdy_d;
  logic                  v_q, v_d;
  logic                  start_q, start_d;
  logic [ML_W-1:0]       len_q, len_d;
  logic [AXI_KEEP_W-1:0] mask_q, mask_d;
  logic [AXI_DATA_W-1:0] data_q, data_d;

  logic                  proc;
  logic [AXI_DATA_W-1:0] cur_data;
  logic [AXI_KEEP_W-1:0] cur_keep;
  logic                  cur_last;
  logic                  cur_user;
  logic [2:0]            spos;
  logic                  stop;
  logic [2:0]            stop_pos;
  logic                  o_v;
  logic                  o_start;
  logic [ML_W-1:0]       o_len;
  logic [AXI_KEEP_W-1:0] o_mask;
  logic [ML_W-1:0]       nl;
  logic [7:0]            b;

  always_comb begin
    st_d    = st_q;
    hcnt_d  = hcnt_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mlen_d  = mlen_q;
    lenlo_d = lenlo_q;
    lph_d   = lph_q;
    first_d = first_q;
    hold_d  = hold_q;
    pos_d   = pos_q;
    hdata_d = hdata_q;
    hkeep_d = hkeep_q;
    hlast_d = hlast_q;
    rdy_d   = 1'b1;
    v_d     = 1'b0;
    start_d = 1'b0;
    len_d   = len_q;
    mask_d  = '0;
    data_d  = data_q;

    proc     = (bus.upd_axis_tvalid_i & rdy_q) | hold_q;
    cur_data = hold_q ? hdata_q : bus.upd_axis_tdata_i;
    cur_keep = hold_q ? hkeep_q : bus.upd_axis_tkeep_i;
    cur_last = hold_q ? hlast_q : bus.upd_axis_tlast_i;
    cur_user = hold_q ? 1'b0    : bus.upd_axis_tuser_i;
    spos     = hold_q ? pos_q   : '0;
    stop     = 1'b0;
    stop_pos = '0;
    o_v      = 1'b0;
    o_start  = 1'b0;
    o_len    = '0;
    o_mask   = '0;
    nl       = '0;
    b        = '0;

    if (proc) begin
      data_d = cur_data;
      if (cur_user) begin
        st_d = DRAIN;
      end else begin
        // Lane walk: the first lane that would open output for a second message
        // stops the walk unprocessed, so the held beat resumes exactly there.
        for (int unsigned i = 0; i < AXI_KEEP_W; i++) begin
          if (!stop && i >= 32'(spos) && cur_keep[i]) begin
            b = cur_data[8*i +: 8];
            case (st_d)
              HDR: begin
                if (hcnt_d == 5'd18) cnt_d[7:0] = b;
                if (hcnt_d == 5'd19) begin
                  cnt_d[15:8] = b;
                  if (cnt_d == '0 || cnt_d == '1) st_d = DRAIN;
                  else begin
                    st_d  = LEN;
                    lph_d = 1'b0;
                  end
                end
                hcnt_d = hcnt_d + 5'd1;
              end
              LEN: begin
                if (!lph_d) begin
                  lenlo_d = b;
                  lph_d   = 1'b1;
                end else begin
                  nl = {b, lenlo_d};
                  if (nl == '0) begin
                    if (o_v) begin
                      stop     = 1'b1;
                      stop_pos = 3'(i);
                    end else begin
                      o_v     = 1'b1;
                      o_start = 1'b1;
                      o_len   = '0;
                      lph_d   = 1'b0;
                      cnt_d   = cnt_d - 16'd1;
                      st_d    = (cnt_d == '0) ? DRAIN : LEN;
                    end
                  end else begin
                    mlen_d  = nl;
                    rem_d   = nl;
                    first_d = 1'b1;
                    lph_d   = 1'b0;
                    st_d    = PAY;
                  end
                end
              end
              PAY: begin
                if (o_v && first_d) begin
                  stop     = 1'b1;
                  stop_pos = 3'(i);
                end else begin
                  o_v = 1'b1;
                  if (first_d) begin
                    o_start = 1'b1;
                    o_len   = mlen_d;
                    first_d = 1'b0;
                  end
                  o_mask[i] = 1'b1;
                  rem_d     = rem_d - 16'd1;
                  if (rem_d == '0) begin
                    cnt_d = cnt_d - 16'd1;
                    st_d  = (cnt_d == '0) ? DRAIN : LEN;
                    lph_d = 1'b0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end

      if (stop) begin
        hold_d  = 1'b1;
        pos_d   = stop_pos;
        hdata_d = cur_data;
        hkeep_d = cur_keep;
        hlast_d = cur_last;
        rdy_d   = 1'b0;
      end else begin
        hold_d = 1'b0;
        pos_d  = '0;
        if (cur_last) begin
          st_d    = HDR;
          hcnt_d  = '0;
          cnt_d   = '0;
          rem_d   = '0;
          lph_d   = 1'b0;
          first_d = 1'b0;
          lenlo_d = '0;
        end
      end

      v_d     = o_v;
      start_d = o_start;
      mask_d  = o_mask;
      if (o_start) len_d = o_len;
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      st_q    <= HDR;
      hcnt_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      mlen_q  <= '0;
      lenlo_q <= '0;
      lph_q   <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= 1'b0;
      pos_q   <= '0;
      hdata_q <= '0;
      hkeep_q <= '0;
      hlast_q <= 1'b0;
      rdy_q   <= 1'b0;
      v_q     <= 1'b0;
      start_q <= 1'b0;
      len_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      st_q    <= st_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      mlen_q  <= mlen_d;
      lenlo_q <= lenlo_d;
      lph_q   <= lph_d;
      first_q <= first_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
      hdata_q <= hdata_d;
      hkeep_q <= hkeep_d;
      hlast_q <= hlast_d;
      rdy_q   <= rdy_d;
      v_q     <= v_d;
      start_q <= start_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  assign bus.upd_axis_tready_o = rdy_q;
  assign bus.mold_msg_v_o      = v_q;
  assign bus.mold_msg_start_o  = start_q;
  assign bus.mold_msg_len_o    = len_q;
  assign bus.mold_msg_mask_o   = mask_q;
  assign bus.mold_msg_data_o   = data_q;

endmodule

// File: tb/tb_moldudp64_top.sv
// Bench for moldudp64_top: a byte-stream reference model predicts message records per packet.
module tb_moldudp64_top;

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic [7:0]  mask;
    logic [63:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  moldudp64_top_if bus ();

  moldudp64_top dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int nlow  = 0;
  rec_t exp_q[$];
  rec_t cr;

  logic [63:0] pd[16];
  logic [7:0]  pk[16];
  logic        pu[16];
  int          pn;
  bit          plast;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int k, input logic [63:0] d, input logic [7:0] kp, input logic u);
    pd[k] = d;
    pk[k] = kp;
    pu[k] = u;
  endtask

  // Reference: flatten kept bytes up to the first errored beat, then read the
  // header and message blocks; each beat touched by a message yields one record.
  task automatic model_pkt();
    logic [7:0]  bv[$];
    int          bb[$];
    int          bl[$];
    int          sz, idx, cur;
    logic [15:0] cnt, ln;
    rec_t        r;
    r = '{default: '0};
    for (int k = 0; k < pn; k++) begin
      if (pu[k]) break;
      for (int l = 0; l < 8; l++)
        if (pk[k][l]) begin
          bv.push_back(pd[k][8*l +: 8]);
          bb.push_back(k);
          bl.push_back(l);
        end
    end
    sz = bv.size();
    if (sz < 20) return;
    cnt = {bv[19], bv[18]};
    if (cnt == 16'h0000 || cnt == 16'hFFFF) return;
    idx = 20;
    for (int m = 0; m < int'(cnt); m++) begin
      if (idx + 2 > sz) return;
      ln = {bv[idx+1], bv[idx]};
      if (ln == 16'd0) begin
        r.start = 1'b1; r.len = 16'd0; r.mask = 8'h00; r.data = pd[bb[idx+1]];
        exp_q.push_back(r);
        idx += 2;
        continue;
      end
      idx += 2;
      cur = -1;
      for (int j = 0; j < int'(ln); j++) begin
        if (idx >= sz) break;
        if (bb[idx] != cur) begin
          if (cur >= 0) exp_q.push_back(r);
          cur = bb[idx];
          r.start = (j == 0);
          r.len = ln;
          r.mask = 8'h00;
          r.data = pd[cur];
        end
        r.mask[bl[idx]] = 1'b1;
        idx++;
      end
      if (cur >= 0) exp_q.push_back(r);
    end
  endtask

  task automatic send_pkt(input bit bubble);
    int to;
    for (int k = 0; k < pn; k++) begin
      if (bubble) begin
        bus.upd_axis_tvalid_i = 1'b0;
        idle(1);
      end
      bus.upd_axis_tvalid_i = 1'b1;
      bus.upd_axis_tdata_i  = pd[k];
      bus.upd_axis_tkeep_i  = pk[k];
      bus.upd_axis_tlast_i  = plast && (k == pn - 1);
      bus.upd_axis_tuser_i  = pu[k];
      to = 0;
      while (!bus.upd_axis_tready_o && to < 50) begin
        idle(1);
        to++;
      end
      if (to >= 50) chk("tready_timeout", 64'd0, 64'd1);
      idle(1);
    end
    bus.upd_axis_tvalid_i = 1'b0;
    bus.upd_axis_tlast_i  = 1'b0;
    bus.upd_axis_tuser_i  = 1'b0;
  endtask

  task automatic load_p1();
    set_beat(0, 64'hF0F0F0F0_DEADBEEF, 8'hFF, 1'b0);
    set_beat(1, 64'hF0F0F0F0_F0F0F0F0, 8'hFF, 1'b0);
    set_beat(2, 64'hFFFF_0010_0001_F0F0, 8'hFF, 1'b0);
    set_beat(3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0);
    set_beat(4, 64'h00BB_BBBB_BBBB_BBBB, 8'h0F, 1'b0);
    pn = 5;
    plast = 1'b1;
  endtask

  task automatic load_p3();
    set_beat(0, 64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    set_beat(1, 64'h5555_6666_7777_8888, 8'hFF, 1'b0);
    set_beat(2, 64'h055A_0001_0002_2222, 8'hFF, 1'b0);
    set_beat(3, 64'h7766_5544_3322_1100, 8'hFF, 1'b0);
    pn = 4;
    plast = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!nreset) begin
      if (bus.mold_msg_v_o) begin
        if (exp_q.size() == 0) chk("extra_output", 64'd1, 64'd0);
        else begin
          cr = exp_q.pop_front();
          chk("msg_ctl", {39'd0, bus.mold_msg_start_o, bus.mold_msg_len_o, bus.mold_msg_mask_o},
              {39'd0, cr.start, cr.len, cr.mask});
          chk("msg_data", bus.mold_msg_data_o, cr.data);
        end
      end
      if (!bus.upd_axis_tready_o) nlow++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nl0;
    bus.upd_axis_tvalid_i = 1'b0;
    bus.upd_axis_tkeep_i  = '0;
    bus.upd_axis_tdata_i  = '0;
    bus.upd_axis_tlast_i  = 1'b0;
    bus.upd_axis_tuser_i  = 1'b0;
    for (int k = 0; k < 16; k++) set_beat(k, 64'd0, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_v", bus.mold_msg_v_o, 0);
    chk("rst_start", bus.mold_msg_start_o, 0);
    chk("rst_len", bus.mold_msg_len_o, 0);
    chk("rst_mask", bus.mold_msg_mask_o, 0);
    chk("rst_data", bus.mold_msg_data_o, 0);
    chk("rst_tready", bus.upd_axis_tready_o, 0);
    @(posedge clk);
    #1 nreset = 1'b0;
    idle(1);
    chk("rel_tready", bus.upd_axis_tready_o, 1);
    chk("rel_v", bus.mold_msg_v_o, 0);
    idle(2);

    // Single message, len 16, truncated by tkeep on the tlast beat
    load_p1();
    model_pkt();
    chk("p1_model_n", exp_q.size(), 3);
    chk("p1_pin0", {exp_q[0].start, exp_q[0].len, exp_q[0].mask}, {1'b1, 16'd16, 8'hC0});
    chk("p1_pin1", {exp_q[1].start, exp_q[1].mask}, {1'b0, 8'hFF});
    chk("p1_pin2", {exp_q[2].start, exp_q[2].mask}, {1'b0, 8'h0F});
    send_pkt(1'b1);
    idle(4);
    chk("p1_drained", exp_q.size(), 0);
    chk("p1_len_hold", bus.mold_msg_len_o, 16);

    // Three messages, two sharing beat 3 with a zero-length third
    set_beat(0, 64'h0001_0203_0405_0607, 8'hFF, 1'b0);
    set_beat(1, 64'h0809_0A0B_0C0D_0E0F, 8'hFF, 1'b0);
    set_beat(2, 64'hA2A1_0003_0003_1111, 8'hFF, 1'b0);
    set_beat(3, 64'h7700_00B2_B100_02A3, 8'hFF, 1'b0);
    pn = 4;
    plast = 1'b1;
    model_pkt();
    chk("p2_model_n", exp_q.size(), 4);
    chk("p2_pin1", {exp_q[1].start, exp_q[1].len, exp_q[1].mask}, {1'b0, 16'd3, 8'h01});
    chk("p2_pin2", {exp_q[2].start, exp_q[2].len, exp_q[2].mask}, {1'b1, 16'd2, 8'h18});
    chk("p2_pin3", {exp_q[3].start, exp_q[3].len, exp_q[3].mask}, {1'b1, 16'd0, 8'h00});
    nl0 = nlow;
    send_pkt(1'b0);
    idle(5);
    chk("p2_tready_low", nlow - nl0, 2);
    chk("p2_drained", exp_q.size(), 0);

    // Length field split across lane 7 / next lane 0
    load_p3();
    model_pkt();
    chk("p3_model_n", exp_q.size(), 2);
    chk("p3_pin1", {exp_q[1].start, exp_q[1].len, exp_q[1].mask}, {1'b1, 16'd5, 8'h3E});
    send_pkt(1'b0);
    idle(4);
    chk("p3_drained", exp_q.size(), 0);

    // End-of-session packet, then a normal one
    set_beat(0, 64'h0101_0101_0101_0101, 8'hFF, 1'b0);
    set_beat(1, 64'h0202_0202_0202_0202, 8'hFF, 1'b0);
    set_beat(2, 64'h0000_0005_FFFF_3333, 8'hFF, 1'b0);
    pn = 3;
    plast = 1'b1;
    model_pkt();
    chk("p4_model_n", exp_q.size(), 0);
    send_pkt(1'b0);
    idle(3);
    load_p1();
    model_pkt();
    send_pkt(1'b0);
    idle(4);
    chk("p5_drained", exp_q.size(), 0);

    // Errored beat 3 suppresses the rest; next packet parses from the header
    load_p1();
    pu[3] = 1'b1;
    model_pkt();
    chk("p6_model_n", exp_q.size(), 1);
    send_pkt(1'b0);
    idle(4);
    load_p3();
    model_pkt();
    send_pkt(1'b1);
    idle(4);
    chk("p7_drained", exp_q.size(), 0);

    // Reset in the middle of a packet
    load_p1();
    pn = 3;
    plast = 1'b0;
    model_pkt();
    send_pkt(1'b0);
    idle(3);
    nreset = 1'b1;
    idle(2);
    @(negedge clk);
    chk("mrst_v", bus.mold_msg_v_o, 0);
    chk("mrst_mask", bus.mold_msg_mask_o, 0);
    chk("mrst_len", bus.mold_msg_len_o, 0);
    @(posedge clk);
    #1 nreset = 1'b0;
    idle(1);
    chk("mrst_tready", bus.upd_axis_tready_o, 1);
    load_p3();
    model_pkt();
    send_pkt(1'b0);
    idle(6);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
